// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner.
// Lights one digit at a time for DWELL_CYC cycles and puts BLANK_CYC all-off
// cycles between digits. Each digit is hex-decoded or raw, with its own
// decimal point and blink control. All outputs come straight from flops.
module seg7_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 25
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic [4*N_DIGITS-1:0] Hex_in,
    input  logic [8*N_DIGITS-1:0] Raw_in,
    input  logic [N_DIGITS-1:0]   Raw_mode,
    input  logic [N_DIGITS-1:0]   Dp_in,
    input  logic [N_DIGITS-1:0]   Blink_en,
    output logic [N_DIGITS-1:0]   Digit_n,
    output logic [7:0]            Seg_n,
    output logic                  Frame_tick
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FRM_W   = $clog2(BLINK_DIV + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_DIV - 1);
    localparam bit               NO_BLANK   = (BLANK_CYC == 0);

    typedef enum logic {
        ST_BLANK   = 1'b0,
        ST_DISPLAY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [N_DIGITS-1:0] digit_n_q, digit_n_d;
    logic [7:0]         seg_n_q, seg_n_d;
    logic               frame_tick_q, frame_tick_d;

    // Control strobes from the sequencer to the output stage.
    logic               load;     // entering DISPLAY: capture digit idx_d
    logic               go_dark;  // entering BLANK or disabled: all off

    // Digit fields selected by the index of the digit about to be shown.
    logic [3:0]         hex_sel;
    logic [7:0]         raw_sel;
    logic               raw_mode_sel;
    logic               dp_sel;
    logic               blink_sel;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Sequencer: BLANK/DISPLAY timing, digit index, frame and blink phase.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_tick_d  = 1'b0;
        load          = 1'b0;
        go_dark       = 1'b0;

        if (!Enable) begin
            // Park in BLANK so re-enabling always starts with a full gap.
            state_d = ST_BLANK;
            cnt_d   = '0;
            go_dark = 1'b1;
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    if (NO_BLANK || cnt_q == BLANK_LAST) begin
                        state_d = ST_DISPLAY;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_tick_d = 1'b1;
                            if (frame_cnt_q == FRM_LAST) begin
                                frame_cnt_d   = '0;
                                blink_phase_d = ~blink_phase_q;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                        if (NO_BLANK) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_BLANK;
                            go_dark = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: pick the next digit's fields and capture them on DISPLAY entry.
    always_comb begin
        hex_sel      = '0;
        raw_sel      = '0;
        raw_mode_sel = 1'b0;
        dp_sel       = 1'b0;
        blink_sel    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                hex_sel      = Hex_in[4*i +: 4];
                raw_sel      = Raw_in[8*i +: 8];
                raw_mode_sel = Raw_mode[i];
                dp_sel       = Dp_in[i];
                blink_sel    = Blink_en[i];
            end
        end

        // Hold the captured image for the whole dwell.
        digit_n_d = digit_n_q;
        seg_n_d   = seg_n_q;
        if (go_dark) begin
            digit_n_d = '1;
            seg_n_d   = 8'hFF;
        end else if (load) begin
            if (blink_sel && blink_phase_d) begin
                // Blinked-off slot keeps its timing but shows nothing.
                digit_n_d = '1;
                seg_n_d   = 8'hFF;
            end else begin
                digit_n_d = ~(N_DIGITS'(1) << idx_d);
                seg_n_d   = raw_mode_sel ? ~raw_sel : ~{dp_sel, hex7(hex_sel)};
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digit_n_q     <= '1;
            seg_n_q       <= 8'hFF;
            frame_tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_n_q     <= digit_n_d;
            seg_n_q       <= seg_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign Digit_n    = digit_n_q;
    assign Seg_n      = seg_n_q;
    assign Frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised, clocked multiplexed 7-segment display scanner; successor to the fixed 4-digit combinational image selector.
- Strobes N_DIGITS common-anode digits in turn, each with its own dwell time, and inserts an all-off blanking gap between digits to suppress ghosting.
- Each digit is either hex-decoded or raw, with its own decimal point and blink control.
- Sits between the counter/level/status logic and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (>=1)
DWELL_CYC, 50000, clock cycles each digit is lit (>=1)
BLANK_CYC, 500, all-off cycles between digits (0 = no blanking)
BLINK_DIV, 25, complete scan frames per blink phase toggle (>=1)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  synchronous reset, active-low
Enable  in  1  1 = scan; 0 = display dark, scan paused
Hex_in  in  4*N_DIGITS  nibble per digit; digit i = [4i+3:4i]
Raw_in  in  8*N_DIGITS  raw active-high pattern {P,G,F,E,D,C,B,A} per digit; digit i = [8i+7:8i]
Raw_mode  in  N_DIGITS  per digit: 1 = use Raw_in, 0 = hex-decode Hex_in
Dp_in  in  N_DIGITS  per-digit decimal point (hex mode only; OR-ed into P)
Blink_en  in  N_DIGITS  per-digit blink enable
Digit_n  out  N_DIGITS  digit strobes, active-low, one-hot-low or all 1
Seg_n  out  8  {P,G,F,E,D,C,B,A}, active-low
Frame_tick  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (Reset_n=0 at an edge): Digit_n=all 1, Seg_n=8'hFF, Frame_tick=0, idx=0, state=BLANK, dwell/blank counter=0, frame counter=0, blink phase=0 (visible). Reset mid-dwell takes effect at the next edge, with no partial state kept.
- FSM, two states:
  - BLANK: outputs dark; count BLANK_CYC cycles, then go to DISPLAY. When BLANK_CYC=0, BLANK lasts 0 cycles (DISPLAY follows DISPLAY directly).
  - DISPLAY: Digit_n[idx]=0 for exactly DWELL_CYC cycles; then idx <= (idx==N_DIGITS-1) ? 0 : idx+1; go to BLANK.
- Segment data for idx is captured on entry to DISPLAY and held for the whole dwell. Input changes mid-dwell become visible only at the next visit.
- All outputs are registered. Digit_n and Seg_n change on the same edge.
- Hex decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. P=Dp_in[idx]. Seg_n = ~pattern.
- Raw mode: Seg_n = ~Raw_in slice; Dp_in ignored.
- Frame_tick=1 for the single cycle after DISPLAY of idx N_DIGITS-1 ends.
- Blink:
  - Frame counter increments on each Frame_tick. When it reaches BLINK_DIV-1 and a frame completes, it wraps to 0 and blink phase toggles.
  - While phase=1, a digit with Blink_en=1 is dark for its slot (Digit_n stays all 1, Seg_n=FF), but its slot timing is unchanged.
- Enable=0: next edge Digit_n=all 1, Seg_n=FF. State is forced to BLANK with the counter cleared. idx, frame counter and blink phase are held, and no Frame_tick is produced.
- Enable 0->1: a full BLANK_CYC gap, then resume at the held idx.
- N_DIGITS=1: idx stays 0. Every dwell end is a frame end.
- idx width = max(1,clog2(N_DIGITS)). Counter widths are sized from the parameters, with no overflow at maximum values.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with random inputs -> Digit_n=4'hF, Seg_n=8'hFF, Frame_tick=0 every cycle. Release -> Digit_n=4'hE after exactly BLANK_CYC cycles.
- Scan timing (N=4, DWELL_CYC=3, BLANK_CYC=1, Enable=1):
  - Digit_n sequence is F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7, then repeats.
  - Frame_tick is high on the cycle after the last 7.
  - Repeat with BLANK_CYC=0 -> no F gaps.
- Decode:
  - Hex_in digit0 = 0..F, Raw_mode=0, Dp=0 -> Seg_n = ~table, e.g. 1 -> F9, 8 -> 80.
  - Dp_in[0]=1 with 8 -> 00.
  - Raw_mode[2]=1, Raw_in slice=8'hA5 -> Seg_n=5A during digit 2 slot.
- Capture: change Hex_in digit1 from 3 to 5 mid-dwell -> Seg_n stays B0 for the rest of that dwell, shows 92 on the next visit.
- Blink (BLINK_DIV=2, Blink_en=4'b0010):
  - Frames 0-1: digit1 lit.
  - Frames 2-3: digit1 slot dark (Digit_n=F), other digits normal.
  - Frames 4-5: digit1 lit again.
- Enable/reset mid-operation:
  - Drop Enable during digit 2 dwell -> dark next cycle. Re-assert -> BLANK_CYC gap, then Digit_n=B for a full DWELL_CYC.
  - Assert Reset_n=0 mid-dwell -> next edge dark, idx restarts at 0.
